// File: rtl/shift_unit_seq_pkg.sv
// ----------------------------------------------------------------------------
// shift_unit_seq_pkg
// Shared definitions for the sequential shift unit: operation encodings,
// FSM state encodings, datapath width, shift-amount limit and the helper that
// saturates the 32-bit unsigned shift amount to the 6-bit step counter range.
// ----------------------------------------------------------------------------
package shift_unit_seq_pkg;

   localparam int WIDTH     = 32;
   localparam int MAX_SHIFT = 32;

   // Operation encodings (2'b11 is decoded as a logical right shift)
   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // min(y, MAX_SHIFT) as a 6-bit count; y is unsigned, so any set bit above
   // bit 4 means the amount is at least 32.
   function automatic logic [5:0] clamp_shift(input logic [WIDTH-1:0] y);
      if (|y[WIDTH-1:5])
         return 6'(MAX_SHIFT);
      else
         return {1'b0, y[4:0]};
   endfunction

endpackage

// File: rtl/shift_step_1pos.sv
// ----------------------------------------------------------------------------
// shift_step_1pos
// Combinational single-position shifter used once per SHIFT cycle.
// Ports:
//   data    [31:0] in  : value to shift
//   dir            in  : 0 = left (LSB gets 0), 1 = right (MSB gets fill)
//   fill           in  : bit shifted into the MSB on a right shift
//   shifted [31:0] out : data shifted by exactly one position
// ----------------------------------------------------------------------------
module shift_step_1pos
   import shift_unit_seq_pkg::*;
(
   input  logic [WIDTH-1:0] data,
   input  logic             dir,
   input  logic             fill,
   output logic [WIDTH-1:0] shifted
);

   assign shifted = dir ? {fill, data[WIDTH-1:1]} : {data[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/shift_unit_seq.sv
// ----------------------------------------------------------------------------
// shift_unit_seq
// Multi-cycle barrel-free shifter: shifts one bit position per clock until the
// captured shift amount (saturated at 32) is exhausted.
// Ports:
//   clk          in  : clock, rising edge
//   rst          in  : synchronous active-high reset
//   start        in  : request; accepted only in IDLE or DONE
//   op    [1:0]  in  : 00 SLL, 01 SRL, 10 SRA, 11 SRL
//   X     [31:0] in  : operand, captured on acceptance
//   Y     [31:0] in  : unsigned shift amount, captured on acceptance
//   busy         out : high while shifting
//   done         out : one-cycle pulse, Z valid
//   Z     [31:0] out : result, updated only on entry to DONE
// Configuration macro: SHIFT_ARITH_EN -- when defined, op=10 sign-fills from
// X[31]; otherwise op=10 is a logical right shift and no sign bit is kept.
// ----------------------------------------------------------------------------
module shift_unit_seq
   import shift_unit_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Z
);

   state_t           state;
   logic [WIDTH-1:0] data;
   logic [5:0]       count;
   logic [1:0]       op_q;
   logic             fill;
   logic             dir;
   logic             accept;
   logic [5:0]       load_count;
   logic [WIDTH-1:0] stepped;

   assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign load_count = clamp_shift(Y);
   assign dir        = (op_q != OP_SLL);

`ifdef SHIFT_ARITH_EN
   logic fill_q;
   assign fill = fill_q;

   always_ff @(posedge clk) begin
      if (rst)
         fill_q <= 1'b0;
      else if (accept)
         fill_q <= (op == OP_SRA) && X[WIDTH-1];
   end
`else
   assign fill = 1'b0;
`endif

   shift_step_1pos u_step (
      .data    (data),
      .dir     (dir),
      .fill    (fill),
      .shifted (stepped)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         Z     <= '0;
         count <= '0;
         data  <= '0;
         op_q  <= OP_SLL;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  data  <= X;
                  op_q  <= op;
                  count <= load_count;
                  // A zero shift amount completes immediately with Z = X
                  if (load_count == 6'd0) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     Z     <= X;
                  end else begin
                     state <= ST_SHIFT;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            ST_SHIFT: begin
               data  <= stepped;
               count <= count - 6'd1;
               // Last step: publish the shifted value as it enters DONE
               if (count == 6'd1) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  Z     <= stepped;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_unit_seq.sv
module tb_shift_unit_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op_s;
   logic [31:0] x_s;
   logic [31:0] y_s;
   logic        busy;
   logic        done;
   logic [31:0] Z;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] sb[$];
   logic [31:0] last_z;

   always #5 clk = ~clk;

   shift_unit_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op_s),
      .X     (x_s),
      .Y     (y_s),
      .busy  (busy),
      .done  (done),
      .Z     (Z)
   );

   function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
      logic sra;
      sra = 1'b0;
`ifdef SHIFT_ARITH_EN
      sra = (o == 2'b10);
`endif
      if (o == 2'b00)
         return (y >= 32) ? 32'h0 : (x << y[4:0]);
      if (sra)
         return (y >= 32) ? {32{x[31]}} : 32'($signed(x) >>> y[4:0]);
      return (y >= 32) ? 32'h0 : (x >> y[4:0]);
   endfunction

   // Drives one request and waits for done (bounded). Pushes exp onto the
   // scoreboard; the calling test pops and compares.
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_z, output int lat, output int busy_cyc,
                        output logic [31:0] z_obs);
      @(negedge clk);
      start = 1'b1; op_s = o; x_s = x; y_s = y;
      sb.push_back(exp_z);
      lat = -1; busy_cyc = 0; z_obs = 'x;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0; op_s = 2'($urandom); x_s = $urandom; y_s = $urandom;
         end
         if (busy) busy_cyc++;
         if (done) begin
            lat = k; z_obs = Z;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; op_s = 2'b00; x_s = 32'h1234_5678; y_s = 32'd3;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++;
      if (Z !== 32'h0) begin n_fail++; $display("FAIL reset_z: got %h expected 00000000", Z); end
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_sll();
      int lat, bc; logic [31:0] z, e;
      do_op(2'b00, 32'h0000_0001, 32'd4, 32'h0000_0010, lat, bc, z);
      e = sb.pop_front();
      n_checks++;
      if (z !== e) begin n_fail++; $display("FAIL sll_z: got %h expected %h", z, e); end
      n_checks++;
      if (lat != 5) begin n_fail++; $display("FAIL sll_latency: got %0d expected 5", lat); end
      n_checks++;
      if (bc != 4) begin n_fail++; $display("FAIL sll_busy_cycles: got %0d expected 4", bc); end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL sll_done_width: got %b expected 0", done); end
      repeat (2) @(negedge clk);
      n_checks++;
      if (Z !== e) begin n_fail++; $display("FAIL sll_z_hold: got %h expected %h", Z, e); end
   endtask

   task automatic test_sra();
      int lat, bc; logic [31:0] z, e, c;
`ifdef SHIFT_ARITH_EN
      c = 32'hFFFF_FFFF;
`else
      c = 32'h0000_0001;
`endif
      do_op(2'b10, 32'h8000_0000, 32'd31, c, lat, bc, z);
      e = sb.pop_front();
      n_checks++;
      if (z !== e) begin n_fail++; $display("FAIL sra_z: got %h expected %h", z, e); end
      n_checks++;
      if (lat != 32) begin n_fail++; $display("FAIL sra_latency: got %0d expected 32", lat); end
   endtask

   task automatic test_boundaries();
      int lat, bc; logic [31:0] z, e, sfill;
      logic [1:0]  bo[6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b11};
      logic [31:0] bx[6] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h9000_0000,
                             32'h7FFF_FFFF, 32'hF000_000F};
      logic [31:0] by[6] = '{32'd0, 32'd40, 32'hFFFF_FFFF, 32'd32, 32'h8000_0000, 32'd4};
      int          bl[6] = '{1, 33, 33, 33, 33, 5};
`ifdef SHIFT_ARITH_EN
      sfill = 32'hFFFF_FFFF;
`else
      sfill = 32'h0;
`endif
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: e = 32'hDEAD_BEEF;
            3: e = sfill;
            5: e = 32'h0F00_0000;
            default: e = 32'h0;
         endcase
         do_op(bo[i], bx[i], by[i], e, lat, bc, z);
         e = sb.pop_front();
         n_checks++;
         if (z !== e) begin n_fail++; $display("FAIL boundary%0d_z: got %h expected %h", i, z, e); end
         n_checks++;
         if (lat != bl[i]) begin
            n_fail++; $display("FAIL boundary%0d_latency: got %0d expected %0d", i, lat, bl[i]);
         end
      end
   endtask

   task automatic test_random();
      int lat, bc; logic [1:0] o; logic [31:0] x, y, z, e;
      for (int i = 0; i < 8; i++) begin
         o = 2'($urandom);
         x = $urandom;
         y = (i == 7) ? $urandom : 32'($urandom_range(0, 35));
         do_op(o, x, y, ref_shift(o, x, y), lat, bc, z);
         e = sb.pop_front();
         n_checks++;
         if (z !== e) begin
            n_fail++; $display("FAIL random%0d_z: op=%b x=%h y=%h got %h expected %h", i, o, x, y, z, e);
         end
         n_checks++;
         if (lat != ((y >= 32) ? 33 : int'(y) + 1)) begin
            n_fail++; $display("FAIL random%0d_latency: y=%h got %0d", i, y, lat);
         end
      end
   endtask

   task automatic test_ignored_start();
      int lat, ndone; logic [31:0] e, z;
      @(negedge clk);
      start = 1'b1; op_s = 2'b00; x_s = 32'h0000_0001; y_s = 32'd8;
      sb.push_back(32'h0000_0100);
      lat = -1; ndone = 0; z = 'x;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         start = (k == 3);
         if (k == 3) begin op_s = 2'b01; x_s = 32'hFFFF_0000; y_s = 32'd2; end
         if (done) begin
            ndone++;
            if (lat < 0) begin lat = k; z = Z; end
         end
      end
      e = sb.pop_front();
      n_checks++;
      if (z !== e) begin n_fail++; $display("FAIL ignored_z: got %h expected %h", z, e); end
      n_checks++;
      if (lat != 9) begin n_fail++; $display("FAIL ignored_latency: got %0d expected 9", lat); end
      n_checks++;
      if (ndone != 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d expected 1", ndone); end
   endtask

   task automatic test_back_to_back();
      int lat, bc, lat2; logic [31:0] z, e;
      logic b1;
      do_op(2'b01, 32'h0000_00F0, 32'd4, 32'h0000_000F, lat, bc, z);
      e = sb.pop_front();
      n_checks++;
      if (z !== e) begin n_fail++; $display("FAIL b2b_first_z: got %h expected %h", z, e); end
      // Still in the DONE cycle: request the next operation immediately
      start = 1'b1; op_s = 2'b00; x_s = 32'h0000_0003; y_s = 32'd2;
      sb.push_back(32'h0000_000C);
      lat2 = -1; b1 = 1'b0; z = 'x;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin start = 1'b0; b1 = busy; end
         if (done) begin lat2 = k; z = Z; break; end
      end
      e = sb.pop_front();
      n_checks++;
      if (b1 !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle: busy got %b expected 1", b1); end
      n_checks++;
      if (z !== e) begin n_fail++; $display("FAIL b2b_second_z: got %h expected %h", z, e); end
      n_checks++;
      if (lat2 != 3) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 3", lat2); end
      last_z = e;
   endtask

   task automatic test_reset_mid_op();
      int lat, bc, ndone; logic [31:0] z, e;
      @(negedge clk);
      start = 1'b1; op_s = 2'b00; x_s = 32'h0000_0001; y_s = 32'd10;
      @(negedge clk);                 // first SHIFT cycle
      start = 1'b0;
      @(negedge clk);                 // second
      @(negedge clk);                 // third: reset sampled at its closing edge
      n_checks++;
      if (Z !== last_z) begin n_fail++; $display("FAIL midrst_z_before: got %h expected %h", Z, last_z); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
      n_checks++;
      if (Z !== 32'h0) begin n_fail++; $display("FAIL midrst_z: got %h expected 00000000", Z); end
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      n_checks++;
      if (ndone != 0) begin n_fail++; $display("FAIL midrst_activity: got %0d expected 0", ndone); end
      // First request after reset must behave normally
      do_op(2'b01, 32'h8000_0000, 32'd3, 32'h1000_0000, lat, bc, z);
      e = sb.pop_front();
      n_checks++;
      if (z !== e) begin n_fail++; $display("FAIL postrst_z: got %h expected %h", z, e); end
      n_checks++;
      if (lat != 4) begin n_fail++; $display("FAIL postrst_latency: got %0d expected 4", lat); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op_s = 2'b00; x_s = '0; y_s = '0; last_z = '0;
      test_reset();
      test_sll();
      test_sra();
      test_boundaries();
      test_random();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid_op();
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports as listed below.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only when the block is ready (state IDLE or DONE).
REQ-005 op  input  2  shift operation: 00 = SLL, 01 = SRL, 10 = SRA, 11 = SRL.
REQ-006 X  input  32  operand to be shifted; captured when start is accepted.
REQ-007 Y  input  32  unsigned shift amount; captured when start is accepted.
REQ-008 busy  output  1  high while in state SHIFT.
REQ-009 done  output  1  one-cycle pulse marking that Z is valid.
REQ-010 Z  output  32  result register; held stable from the done pulse until the next accepted start.

Function
REQ-011 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 Start SHALL be accepted only in IDLE or DONE. On acceptance:
- the data register loads X;
- op is latched;
- the step counter loads min(Y,32) (6 bits);
- the fill bit is latched.
REQ-013 The fill bit SHALL be X[31] for op=10 when SHIFT_ARITH_EN is defined, and 0 in every other case.
REQ-014 After acceptance, the next state SHALL be SHIFT if the counter is non-zero, and DONE otherwise.
REQ-015 Each SHIFT cycle SHALL shift the data register by exactly one position and decrement the counter.
- SLL: the LSB is filled with 0.
- SRL/SRA: the MSB is filled with the fill bit.
REQ-016 When the counter decrements to 0, SHIFT SHALL go to DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle and Z SHALL equal the data register. DONE SHALL then go to IDLE, or to SHIFT/DONE if a start is accepted in the same cycle.
REQ-018 Latency SHALL be exactly min(Y,32)+1 cycles from the accepting edge to the done cycle.
REQ-019 Y >= 32 SHALL give a result of all fill bits: 0x00000000, or 0xFFFFFFFF for SRA with a negative X.
REQ-020 Y is unsigned; values of 2^31 and above SHALL be treated as >= 32 and never as negative.
REQ-021 start asserted while busy=1 SHALL be ignored, with no effect on state, counter, data or Z.
REQ-022 X, Y and op SHALL be don't-care in every cycle except the accepting cycle.
REQ-023 Z SHALL update only on entry to DONE; in IDLE and SHIFT it SHALL keep the previous result.

Reset
REQ-024 rst=1 SHALL force the following at the next edge, overriding start and aborting any operation in progress:
- state = IDLE;
- busy = 0;
- done = 0;
- Z = 0;
- counter = 0;
- data register = 0.
REQ-025 The first start after rst deasserts SHALL be accepted normally, with no stale state left from an aborted operation.

Configuration
REQ-026 The macro SHIFT_ARITH_EN SHALL select the arithmetic-shift feature.
REQ-027 With SHIFT_ARITH_EN defined, op=10 SHALL perform an arithmetic right shift (sign fill from X[31]).
REQ-028 Without SHIFT_ARITH_EN, op=10 SHALL behave identically to SRL (zero fill), and the sign-latch logic SHALL be absent.

Structure
REQ-029 A shared package SHALL hold:
- the op encodings (OP_SLL, OP_SRL, OP_SRA);
- the state encodings;
- the constant WIDTH=32;
- the constant MAX_SHIFT=32.
REQ-030 One sub-module, shift_step_1pos, SHALL be used. It is purely combinational and does a single-position shift: inputs data[31:0], dir and fill; output data[31:0].
REQ-031 All sequencing, the counter and the registers SHALL reside in shift_unit_seq.

Verification
REQ-032 SLL: op=00, X=0x00000001, Y=4 -> busy for 4 cycles, done 5 cycles after the accepting edge, Z=0x00000010.
REQ-033 SRA (SHIFT_ARITH_EN defined): op=10, X=0x80000000, Y=31 -> Z=0xFFFFFFFF. Without the macro -> Z=0x00000001.
REQ-034 Boundaries:
- Y=0, X=0xDEADBEEF -> done after 1 cycle, Z=0xDEADBEEF;
- Y=40, op=01 -> Z=0x00000000 with 33-cycle latency;
- Y=0xFFFFFFFF -> same as Y=40.
REQ-035 Ignored start: start with Y=8, then start re-pulsed mid-SHIFT with different X/Y -> it is ignored, and exactly one done pulse arrives with the original result.
REQ-036 Back-to-back: start asserted in the DONE cycle -> a new operation is accepted, with no idle cycle in between.
REQ-037 Reset mid-operation: rst asserted in the 3rd SHIFT cycle -> the next cycle shows state IDLE, busy=0, done=0 and Z=0, and no done pulse follows.
